i_bus_autoscatter_seq: RTL and testbench

- One-to-many sequential distributor. It is the write-side counterpart of the output bus autopick collector.
- Takes a single input data stream and scatters consecutive accepted beats across NUM_OUTPUT_DATA output lanes in round-robin order, driven by an internal lane pointer.
- Used to fan a serial stream out to a row of PEs or buffer banks.
- Registered outputs, latency 1.

---
 rtl/i_bus_autoscatter_seq.sv | 90 +++++++++
 tb/tb_i_bus_autoscatter_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i_bus_autoscatter_seq.sv
// i_bus_autoscatter_seq: one-to-many round-robin distributor.
// Each accepted beat is written into the data register of the lane that the
// internal pointer selects. Per-lane valid and wrap are registered pulses.
module i_bus_autoscatter_seq #(
  parameter int NUM_OUTPUT_DATA = 300,
  parameter int DATA_WIDTH      = 16,
  parameter int LANE_W          = (NUM_OUTPUT_DATA > 1) ? $clog2(NUM_OUTPUT_DATA) : 1,
  parameter int CNT_W           = $clog2(NUM_OUTPUT_DATA + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_valid,
  input  logic [DATA_WIDTH-1:0]                 i_data_bus,
  input  logic                                  i_en,
  input  logic                                  i_clear,
  input  logic [CNT_W-1:0]                      i_num_lanes,
  output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
  output logic [LANE_W-1:0]                     o_lane_ptr,
  output logic                                  o_wrap
);

  localparam logic [CNT_W-1:0] N_C = CNT_W'(NUM_OUTPUT_DATA);

  logic [NUM_OUTPUT_DATA-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_OUTPUT_DATA-1:0]                 valid_q, valid_d;
  logic [LANE_W-1:0]                          ptr_q, ptr_d;
  logic                                       wrap_q, wrap_d;

  logic [CNT_W-1:0]  eff_n;
  logic [CNT_W-1:0]  ptr_ext;
  logic [CNT_W-1:0]  tgt;
  logic [LANE_W-1:0] tgt_lane;
  logic              accept;
  logic              last;

  // Target lane selection and next-state for pointer, lane data and pulses
  always_comb begin
    eff_n = i_num_lanes;
    if (i_num_lanes == '0 || i_num_lanes > N_C) begin
      eff_n = N_C;
    end

    // Pointer widened to count width so it can be compared against eff_n;
    // a pointer left beyond a shrunken lane count restarts at lane 0.
    ptr_ext               = '0;
    ptr_ext[LANE_W-1:0]   = ptr_q;
    if (i_clear || ptr_ext >= eff_n) begin
      tgt = '0;
    end else begin
      tgt = ptr_ext;
    end
    tgt_lane = LANE_W'(tgt);
    last     = (tgt == eff_n - CNT_W'(1));
    accept   = i_valid & i_en;

    data_d  = data_q;
    valid_d = '0;
    wrap_d  = 1'b0;
    ptr_d   = i_clear ? '0 : ptr_q;

    if (accept) begin
      data_d[tgt_lane]  = i_data_bus;
      valid_d[tgt_lane] = 1'b1;
      wrap_d            = last;
      ptr_d             = last ? '0 : LANE_W'(tgt + CNT_W'(1));
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data_bus = data_q;
  assign o_lane_ptr = ptr_q;
  assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_i_bus_autoscatter_seq.sv
// Self-checking bench for i_bus_autoscatter_seq with 8 lanes of 16 bits.
module tb_i_bus_autoscatter_seq;

  localparam int N  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data_bus = '0;
  logic          i_en = 1'b0;
  logic          i_clear = 1'b0;
  logic [3:0]    i_num_lanes = '0;
  logic [N-1:0]    o_valid;
  logic [N*DW-1:0] o_data_bus;
  logic [2:0]      o_lane_ptr;
  logic            o_wrap;

  i_bus_autoscatter_seq #(
    .NUM_OUTPUT_DATA(N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_valid(i_valid),
    .i_data_bus(i_data_bus),
    .i_en(i_en),
    .i_clear(i_clear),
    .i_num_lanes(i_num_lanes),
    .o_valid(o_valid),
    .o_data_bus(o_data_bus),
    .o_lane_ptr(o_lane_ptr),
    .o_wrap(o_wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: lane contents as an int array, pointer as an int.
  int           m_ptr = 0;
  int           m_lane[N] = '{default: 0};
  logic [N-1:0] m_valid = '0;
  logic         m_wrap = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int eff;
    int t;
    if (!rst_n) begin
      m_ptr   = 0;
      m_valid = '0;
      m_wrap  = 1'b0;
      for (int k = 0; k < N; k++) m_lane[k] = 0;
    end else begin
      eff = (i_num_lanes == 0 || int'(i_num_lanes) > N) ? N : int'(i_num_lanes);
      if (i_valid && i_en) begin
        if (i_clear || m_ptr >= eff) t = 0;
        else t = m_ptr;
        m_lane[t] = int'(i_data_bus);
        m_valid   = '0;
        m_valid[t] = 1'b1;
        m_wrap    = (t == eff - 1);
        m_ptr     = (t + 1) % eff;
      end else begin
        m_valid = '0;
        m_wrap  = 1'b0;
        if (i_clear) m_ptr = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("valid", 64'(o_valid), 64'(m_valid));
    chk("wrap", 64'(o_wrap), 64'(m_wrap));
    chk("lane_ptr", 64'(o_lane_ptr), 64'(m_ptr));
    for (int k = 0; k < N; k++)
      chk($sformatf("lane%0d", k), 64'(o_data_bus[k*DW +: DW]), 64'(m_lane[k]));
  end

  task automatic step(input logic v, input logic en, input logic clr,
                      input logic [3:0] nl, input logic [DW-1:0] d);
    @(negedge clk);
    #1;
    i_valid = v; i_en = en; i_clear = clr; i_num_lanes = nl; i_data_bus = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    i_valid = 1'b0; i_en = 1'b0; i_clear = 1'b0; i_data_bus = '0;
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] lane(input int k);
    return o_data_bus[k*DW +: DW];
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    #20;
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_data_any", 64'(|o_data_bus), 64'h0);
    chk("rst_ptr", 64'(o_lane_ptr), 64'h0);
    chk("rst_wrap", 64'(o_wrap), 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Four beats over four lanes
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd4, 16'(16'hA0 + i));
      chk("rr_valid", 64'(o_valid), 64'(1 << i));
      chk("rr_wrap", 64'(o_wrap), 64'(i == 3));
    end
    step(1'b0, 1'b0, 1'b0, 4'd4, 16'h0);
    chk("rr_ptr_back0", 64'(o_lane_ptr), 64'h0);
    chk("rr_valid_idle", 64'(o_valid), 64'h0);
    chk("rr_lane0", 64'(lane(0)), 64'hA0);
    chk("rr_lane3", 64'(lane(3)), 64'hA3);

    // Disabled beat is dropped; next enabled beat uses the same lane
    step(1'b1, 1'b1, 1'b0, 4'd4, 16'h11);
    step(1'b1, 1'b0, 1'b0, 4'd4, 16'h55);
    chk("en0_valid", 64'(o_valid), 64'h0);
    chk("en0_ptr", 64'(o_lane_ptr), 64'h1);
    chk("en0_lane1", 64'(lane(1)), 64'hA1);
    step(1'b1, 1'b1, 1'b0, 4'd4, 16'h66);
    chk("en1_valid", 64'(o_valid), 64'h2);
    chk("en1_lane1", 64'(lane(1)), 64'h66);

    // Three active lanes out of eight, seven beats
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd3, 16'(i));
      chk("n3_wrap", 64'(o_wrap), 64'(i == 3 || i == 6));
    end
    step(1'b0, 1'b0, 1'b0, 4'd3, 16'h0);
    chk("n3_lane0", 64'(lane(0)), 64'h7);
    chk("n3_lane1", 64'(lane(1)), 64'h5);
    chk("n3_lane2", 64'(lane(2)), 64'h6);
    chk("n3_upper_zero", 64'(|o_data_bus[N*DW-1:3*DW]), 64'h0);
    chk("n3_ptr", 64'(o_lane_ptr), 64'h1);

    // Clear together with an accepted beat
    step(1'b1, 1'b1, 1'b0, 4'd0, 16'h22);
    chk("pre_clr_ptr", 64'(o_lane_ptr), 64'h2);
    step(1'b1, 1'b1, 1'b1, 4'd0, 16'h99);
    chk("clr_valid", 64'(o_valid), 64'h1);
    chk("clr_lane0", 64'(lane(0)), 64'h99);
    chk("clr_ptr", 64'(o_lane_ptr), 64'h1);

    // Pointer beyond a shrunken lane count
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 4'd0, 16'(16'h40 + i));
    chk("shrink_pre_ptr", 64'(o_lane_ptr), 64'h5);
    step(1'b0, 1'b0, 1'b0, 4'd4, 16'h0);
    chk("shrink_idle_ptr", 64'(o_lane_ptr), 64'h5);
    step(1'b1, 1'b1, 1'b0, 4'd4, 16'h77);
    chk("shrink_valid", 64'(o_valid), 64'h1);
    chk("shrink_lane0", 64'(lane(0)), 64'h77);
    chk("shrink_ptr", 64'(o_lane_ptr), 64'h1);

    // Lane count above N behaves as N
    step(1'b0, 1'b0, 1'b1, 4'd12, 16'h0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd12, 16'(16'hB0 + i));
      chk("big_wrap", 64'(o_wrap), 64'(i == 7));
    end
    chk("big_lane7", 64'(lane(7)), 64'hB7);

    // Single active lane
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd1, 16'(16'hC0 + i));
      chk("one_valid", 64'(o_valid), 64'h1);
      chk("one_wrap", 64'(o_wrap), 64'h1);
      chk("one_ptr", 64'(o_lane_ptr), 64'h0);
    end

    // Asynchronous reset in the middle of a stream
    step(1'b1, 1'b1, 1'b0, 4'd0, 16'h30);
    step(1'b1, 1'b1, 1'b0, 4'd0, 16'h31);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_valid), 64'h0);
    chk("arst_data_any", 64'(|o_data_bus), 64'h0);
    chk("arst_ptr", 64'(o_lane_ptr), 64'h0);
    chk("arst_wrap", 64'(o_wrap), 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_first_valid", 64'(o_valid), 64'h1);
    chk("arst_first_lane0", 64'(lane(0)), 64'h31);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
